// File: rtl/burst_mem_responder_if.sv
// Physical-memory burst bus between a cache-side initiator and the memory responder.
// 64-bit beats, four beats per 256-bit line.
interface burst_mem_responder_if;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [63:0] pmem_wdata;
    logic [63:0] pmem_rdata;
    logic        pmem_resp;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/burst_mem_responder.sv
// Line-addressed backing store answering 4-beat bursts after a fixed latency.
// Optional macro BURST_MEM_PERF_EN builds the completed read/write counters.
module burst_mem_responder #(
    parameter int LATENCY     = 4,
    parameter int DEPTH_LINES = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    burst_mem_responder_if.slave        bus,
    output logic                        proto_err,
    output logic [31:0]                 read_count,
    output logic [31:0]                 write_count
);
    localparam int IDX_W = $clog2(DEPTH_LINES);

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

    state_t           state;
    logic [7:0]       cnt;
    logic [1:0]       beat;
    logic             op_write;
    logic [IDX_W-1:0] idx;

    logic [255:0]     mem [DEPTH_LINES];

    logic req_held;
    logic mem_we;
    logic beat_last;
    logic unused_addr;

    // The request that opened the transaction must stay asserted through the last beat.
    assign req_held    = op_write ? bus.pmem_write : bus.pmem_read;
    assign mem_we      = (state == BURST) && op_write && req_held;
    assign beat_last   = (state == BURST) && (beat == 2'd3) && req_held;
    assign unused_addr = ^bus.pmem_address;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= '0;
            beat           <= '0;
            op_write       <= 1'b0;
            idx            <= '0;
            proto_err      <= 1'b0;
            bus.pmem_resp  <= 1'b0;
            bus.pmem_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.pmem_read ^ bus.pmem_write) begin
                        op_write <= bus.pmem_write;
                        idx      <= bus.pmem_address[5 +: IDX_W];
                        cnt      <= 8'(LATENCY - 1);
                        state    <= WAIT;
                    end else if (bus.pmem_read && bus.pmem_write) begin
                        proto_err <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!req_held) begin
                        proto_err <= 1'b1;
                        state     <= IDLE;
                    end else if (cnt == 8'd0) begin
                        state          <= BURST;
                        beat           <= 2'd0;
                        bus.pmem_resp  <= 1'b1;
                        bus.pmem_rdata <= op_write ? '0 : mem[idx][63:0];
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                BURST: begin
                    if (!req_held) begin
                        proto_err      <= 1'b1;
                        bus.pmem_resp  <= 1'b0;
                        bus.pmem_rdata <= '0;
                        state          <= IDLE;
                    end else if (beat == 2'd3) begin
                        bus.pmem_resp  <= 1'b0;
                        bus.pmem_rdata <= '0;
                        state          <= DONE;
                    end else begin
                        beat           <= beat + 2'd1;
                        bus.pmem_rdata <= op_write ? '0 : mem[idx][{beat + 2'd1, 6'd0} +: 64];
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Store is deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx][{beat, 6'd0} +: 64] <= bus.pmem_wdata;
        end
    end

`ifdef BURST_MEM_PERF_EN
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (beat_last) begin
            if (op_write) wr_cnt <= wr_cnt + 32'd1;
            else          rd_cnt <= rd_cnt + 32'd1;
        end
    end

    assign read_count  = rd_cnt;
    assign write_count = wr_cnt;
`else
    logic unused_last;
    assign unused_last = beat_last;
    assign read_count  = '0;
    assign write_count = '0;
`endif
endmodule

// File: tb/tb_burst_mem_responder.sv
// Randomized scoreboard bench for burst_mem_responder against a line-array model.
module tb_burst_mem_responder;
    localparam int LAT   = 4;
    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        proto_err;
    logic [31:0] read_count;
    logic [31:0] write_count;

    burst_mem_responder_if bus ();

    burst_mem_responder #(.LATENCY(LAT), .DEPTH_LINES(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .proto_err(proto_err), .read_count(read_count), .write_count(write_count)
    );

    typedef struct { bit is_read; logic [63:0] data; } sb_t;
    sb_t sb[$];

    logic [255:0] model [DEPTH];
    int total = 0;
    int bad = 0;
    int rc = 0;
    int wc = 0;
    bit err_exp = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (rst) begin
            if (bus.pmem_resp) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got resp=1 expected no beat pending");
                end else begin
                    e = sb.pop_front();
                    if (e.is_read) check("rdata", bus.pmem_rdata, e.data);
                end
            end else begin
                check("rdata_idle", bus.pmem_rdata, 64'd0);
            end
        end
    end

    function automatic logic [255:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // abort_at > 0: request dropped at that cycle after acceptance (cycle 1 follows the accepting edge)
    task automatic txn(input bit wr, input logic [31:0] addr, input logic [255:0] wline, input int abort_at);
        int idx;
        int k;
        bit aborted;
        bit exp_resp;
        logic [255:0] line;
        idx = int'((addr >> 5) % DEPTH);
        line = model[idx];
        aborted = (abort_at > 0);
        @(negedge clk);
        bus.pmem_read    = !wr;
        bus.pmem_write   = wr;
        bus.pmem_address = addr;
        for (int b = 0; b < 4; b++)
            if (!aborted || abort_at >= LAT + 1 + b) sb.push_back('{!wr, line[64*b +: 64]});
        for (int c = 1; c <= LAT + 5; c++) begin
            @(negedge clk);
            if (c == 1) bus.pmem_address = $urandom;
            exp_resp = (c >= LAT + 1) && (c <= LAT + 4) && (!aborted || c <= abort_at);
            check("resp_timing", {63'd0, bus.pmem_resp}, {63'd0, exp_resp});
            if (wr && c >= LAT + 1 && c <= LAT + 4) begin
                k = c - LAT - 1;
                bus.pmem_wdata = wline[64*k +: 64];
                if (!aborted || c < abort_at) line[64*k +: 64] = wline[64*k +: 64];
            end
            if (c == abort_at || c == LAT + 5) begin
                bus.pmem_read  = 1'b0;
                bus.pmem_write = 1'b0;
            end
        end
        model[idx] = line;
        if (aborted) err_exp = 1'b1;
        else if (wr) wc++;
        else rc++;
        check("proto_err", {63'd0, proto_err}, {63'd0, err_exp});
    endtask

    task automatic check_counts(input string name, input int er, input int ew);
`ifdef BURST_MEM_PERF_EN
        check({name, "_rd"}, {32'd0, read_count}, 64'(er));
        check({name, "_wr"}, {32'd0, write_count}, 64'(ew));
`else
        check({name, "_rd"}, {32'd0, read_count}, 64'(er * 0));
        check({name, "_wr"}, {32'd0, write_count}, 64'(ew * 0));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [255:0] l;
        rst = 1'b0;
        bus.pmem_read = 1'b0;
        bus.pmem_write = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            l = (i == 3) ? {64'd4, 64'd3, 64'd2, 64'd1} : rand_line();
            model[i] = l;
            dut.mem[i] = l;
        end
        #3;
        check("rst_resp", {63'd0, bus.pmem_resp}, 64'd0);
        check("rst_rdata", bus.pmem_rdata, 64'd0);
        check("rst_err", {63'd0, proto_err}, 64'd0);
        check_counts("rst_cnt", 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        txn(1'b0, 32'h0000_0060, '0, 0);
        txn(1'b1, 32'h0000_0080, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 0);
        txn(1'b0, 32'h0000_0080, '0, 0);
        txn(1'b0, 32'h0000_009F, '0, 0);
        txn(1'b1, 32'h0000_8000, rand_line(), 0);
        txn(1'b0, 32'h0000_0000, '0, 0);

        for (int n = 0; n < 20; n++)
            txn(1'($urandom % 2), $urandom & 32'hFFFF_81FF, rand_line(), 0);
        check_counts("mid_cnt", rc, wc);

        // Both requests at once: flagged, never answered.
        @(negedge clk);
        bus.pmem_read = 1'b1;
        bus.pmem_write = 1'b1;
        @(negedge clk);
        bus.pmem_read = 1'b0;
        bus.pmem_write = 1'b0;
        err_exp = 1'b1;
        repeat (LAT + 5) begin
            @(negedge clk);
            check("both_noresp", {63'd0, bus.pmem_resp}, 64'd0);
        end
        check("both_err", {63'd0, proto_err}, 64'd1);

        // Reset in the middle of beat 2 of a read.
        @(negedge clk);
        bus.pmem_read = 1'b1;
        bus.pmem_address = 32'h0000_0060;
        for (int b = 0; b < 4; b++) sb.push_back('{1'b1, model[3][64*b +: 64]});
        repeat (LAT + 3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_resp", {63'd0, bus.pmem_resp}, 64'd0);
        check("arst_rdata", bus.pmem_rdata, 64'd0);
        check("arst_err", {63'd0, proto_err}, 64'd0);
        check_counts("arst_cnt", 0, 0);
        sb.delete();
        bus.pmem_read = 1'b0;
        rc = 0;
        wc = 0;
        err_exp = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        txn(1'b0, 32'h0000_0060, '0, 0);
        txn(1'b0, $urandom & 32'hFFFF_81FF, '0, 0);
        txn(1'b1, 32'h0000_0100, rand_line(), 0);
        txn(1'b0, 32'h0000_0100, '0, 0);
        txn(1'b1, 32'h0000_0100, rand_line(), LAT + 2);
        check_counts("perf_cnt", 3, 1);
        txn(1'b0, 32'h0000_0100, '0, 0);

        txn(1'b0, 32'h0000_0060, '0, 2);
        txn(1'b0, 32'h0000_0060, '0, 0);
        check_counts("final_cnt", rc, wc);

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
